// File: rtl/hazard_stall_controller.sv
// Hazard stall controller: load-use interlock, multi-cycle FP stall sequencing,
// taken-branch flush and a saturating stall-cycle counter.
module hazard_stall_controller (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  IF_ID_Rs,
   input  logic [4:0]  IF_ID_Rt,
   input  logic [4:0]  ID_EX_Rt,
   input  logic        ID_EX_MemRead,
   input  logic        branch_taken,
   input  logic        fp_issue,
   input  logic [3:0]  fp_latency,
   output logic        PCWrite,
   output logic        IF_ID_Write,
   output logic        IF_Flush,
   output logic        ID_EX_Bubble,
   output logic [15:0] stall_count,
   output logic [1:0]  fsm_state
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      FP_WAIT = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t     state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic       load_use;
   logic       stall;
   logic       flush;

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                     ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));

   assign fsm_state = state;

   // Next-state and same-cycle pipeline control; load-use outranks FP issue and flush.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      stall    = 1'b0;
      flush    = 1'b0;
      if (!rst_n) begin
         // Reset holds the front end flushed so no stale instruction survives.
         state_nx = RUN;
         cnt_nx   = 4'd0;
         flush    = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (load_use) begin
                  stall = 1'b1;
               end else if (fp_issue && (fp_latency != 4'd0)) begin
                  stall = 1'b1;
                  // This cycle is the first of N stalls; the counter covers the rest.
                  if (fp_latency == 4'd1) begin
                     state_nx = RELEASE;
                  end else begin
                     cnt_nx   = fp_latency - 4'd1;
                     state_nx = FP_WAIT;
                  end
               end else if (branch_taken) begin
                  flush = 1'b1;
               end
            end
            FP_WAIT: begin
               stall = 1'b1;
               if (cnt == 4'd1) begin
                  state_nx = RELEASE;
                  cnt_nx   = 4'd0;
               end else begin
                  cnt_nx = cnt - 4'd1;
               end
            end
            RELEASE: begin
               // The FP op that just finished is still presented; ignore its fp_issue.
               if (load_use) begin
                  stall = 1'b1;
               end else begin
                  state_nx = RUN;
                  if (branch_taken) flush = 1'b1;
               end
            end
            default: begin
               state_nx = RUN;
               cnt_nx   = 4'd0;
            end
         endcase
      end
      PCWrite      = !stall;
      IF_ID_Write  = !stall;
      IF_Flush     = flush && !stall;
      ID_EX_Bubble = stall;
   end

   // State and FP countdown registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Count every cycle a bubble is injected, sticking at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= 16'd0;
      end else if (ID_EX_Bubble && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller with an expected-result queue.
module tb_hazard_stall_controller;

   logic        clk;
   logic        rst_n;
   logic [4:0]  IF_ID_Rs, IF_ID_Rt, ID_EX_Rt;
   logic        ID_EX_MemRead, branch_taken, fp_issue;
   logic [3:0]  fp_latency;
   logic        PCWrite, IF_ID_Write, IF_Flush, ID_EX_Bubble;
   logic [15:0] stall_count;
   logic [1:0]  fsm_state;

   hazard_stall_controller dut (
      .clk(clk), .rst_n(rst_n),
      .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .ID_EX_Rt(ID_EX_Rt),
      .ID_EX_MemRead(ID_EX_MemRead), .branch_taken(branch_taken),
      .fp_issue(fp_issue), .fp_latency(fp_latency),
      .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_Flush(IF_Flush),
      .ID_EX_Bubble(ID_EX_Bubble), .stall_count(stall_count), .fsm_state(fsm_state)
   );

   // {PCWrite, IF_ID_Write, IF_Flush, ID_EX_Bubble}
   localparam logic [3:0] NORM  = 4'b1100;
   localparam logic [3:0] STALL = 4'b0001;
   localparam logic [3:0] FLUSH = 4'b1110;
   localparam logic [1:0] S_RUN = 2'd0, S_FPW = 2'd1, S_REL = 2'd2;

   typedef struct {
      string      tag;
      logic [3:0] ctl;
      logic [1:0] st;
      logic [15:0] sc;
   } exp_t;

   exp_t        q[$];
   int          total  = 0;
   int          passed = 0;
   logic [15:0] exp_sc = 16'd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] exrt,
                        input logic mr, input logic br, input logic fi, input logic [3:0] fl);
      IF_ID_Rs = rs; IF_ID_Rt = rt; ID_EX_Rt = exrt;
      ID_EX_MemRead = mr; branch_taken = br; fp_issue = fi; fp_latency = fl;
   endtask

   task automatic push(input string tag, input logic [3:0] ctl, input logic [1:0] st);
      exp_t e;
      e.tag = tag; e.ctl = ctl; e.st = st; e.sc = exp_sc;
      q.push_back(e);
   endtask

   // Pop the oldest expectation and compare it with what the DUT shows now.
   task automatic chk();
      exp_t       e;
      logic [3:0] obs;
      e   = q.pop_front();
      obs = {PCWrite, IF_ID_Write, IF_Flush, ID_EX_Bubble};
      total++;
      assert (obs === e.ctl) begin passed++; end
      else $error("FAIL %s ctl: got %b want %b", e.tag, obs, e.ctl);
      total++;
      assert (fsm_state === e.st) begin passed++; end
      else $error("FAIL %s state: got %0d want %0d", e.tag, fsm_state, e.st);
      total++;
      assert (stall_count === e.sc) begin passed++; end
      else $error("FAIL %s stall_count: got %h want %h", e.tag, stall_count, e.sc);
   endtask

   // One clock cycle: expectation queued, checked mid-cycle, model advanced at the edge.
   task automatic cyc(input string tag, input logic [3:0] ctl, input logic [1:0] st);
      push(tag, ctl, st);
      @(negedge clk);
      chk();
      @(posedge clk);
      if (rst_n && ctl[0] && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      cyc("reset", FLUSH, S_RUN);
      cyc("reset_hold", FLUSH, S_RUN);
      rst_n = 1'b1;
      cyc("idle", NORM, S_RUN);

      // Single-cycle load-use on Rs
      drive(5, 1, 5, 1, 0, 0, 0);
      cyc("lu_rs", STALL, S_RUN);
      drive(0, 0, 0, 0, 0, 0, 0);
      cyc("lu_rs_after", NORM, S_RUN);

      // Zero register never hazards
      drive(3, 0, 0, 1, 0, 0, 0);
      cyc("zero_reg", NORM, S_RUN);

      // Load-use on Rt, then same match without a load
      drive(2, 7, 7, 1, 0, 0, 0);
      cyc("lu_rt", STALL, S_RUN);
      drive(2, 7, 7, 0, 0, 0, 0);
      cyc("no_load", NORM, S_RUN);

      // Taken branch flush; fp latency 0 is a no-op
      drive(0, 0, 0, 0, 1, 0, 0);
      cyc("branch", FLUSH, S_RUN);
      drive(0, 0, 0, 0, 0, 1, 0);
      cyc("fp_lat0", NORM, S_RUN);

      // FP latency 4 held; branch and load-use ignored while waiting
      drive(0, 0, 0, 0, 0, 1, 4);
      cyc("fp4_c1", STALL, S_RUN);
      cyc("fp4_c2", STALL, S_FPW);
      drive(9, 9, 9, 1, 1, 1, 4);
      cyc("fp4_c3_ign", STALL, S_FPW);
      drive(0, 0, 0, 0, 0, 1, 4);
      cyc("fp4_c4", STALL, S_FPW);
      cyc("fp4_release", NORM, S_REL);
      drive(0, 0, 0, 0, 0, 0, 0);
      cyc("fp4_run", NORM, S_RUN);

      // FP latency 1 goes straight to RELEASE, which still honours a branch
      drive(0, 0, 0, 0, 0, 1, 1);
      cyc("fp1", STALL, S_RUN);
      drive(0, 0, 0, 0, 1, 1, 1);
      cyc("fp1_rel_br", FLUSH, S_REL);
      drive(0, 0, 0, 0, 0, 0, 0);
      cyc("fp1_run", NORM, S_RUN);

      // Load-use beats branch; flush on the following cycle
      drive(4, 0, 4, 1, 1, 0, 0);
      cyc("lu_br", STALL, S_RUN);
      drive(0, 0, 0, 0, 1, 0, 0);
      cyc("br_after_lu", FLUSH, S_RUN);

      // Load-use beats fp_issue; fp re-evaluated next; RELEASE holds on load-use
      drive(6, 0, 6, 1, 0, 1, 2);
      cyc("lu_fp", STALL, S_RUN);
      drive(0, 0, 0, 0, 0, 1, 2);
      cyc("fp2_c1", STALL, S_RUN);
      cyc("fp2_c2", STALL, S_FPW);
      drive(8, 0, 8, 1, 0, 1, 2);
      cyc("rel_lu", STALL, S_REL);
      drive(0, 0, 0, 0, 0, 1, 2);
      cyc("rel_exit", NORM, S_REL);
      drive(0, 0, 0, 0, 0, 0, 0);
      cyc("rel_run", NORM, S_RUN);

      // Reset in the 3rd FP_WAIT cycle of a latency-15 op
      drive(0, 0, 0, 0, 0, 1, 15);
      cyc("fp15_c1", STALL, S_RUN);
      cyc("fp15_w1", STALL, S_FPW);
      cyc("fp15_w2", STALL, S_FPW);
      push("fp15_w3", STALL, S_FPW);
      @(negedge clk);
      chk();
      #2;
      rst_n  = 1'b0;
      exp_sc = 16'd0;
      #1;
      push("async_rst", FLUSH, S_RUN);
      chk();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      cyc("post_rst", NORM, S_RUN);

      // Saturation: 0xFFFE stall cycles, then three more
      drive(5, 0, 5, 1, 0, 0, 0);
      repeat (65534) @(posedge clk);
      exp_sc = 16'hFFFE;
      #1;
      cyc("sat_fffe", STALL, S_RUN);
      cyc("sat_ffff", STALL, S_RUN);
      cyc("sat_hold", STALL, S_RUN);
      drive(0, 0, 0, 0, 0, 0, 0);
      cyc("sat_final", NORM, S_RUN);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: `clk` (rising edge) and `rst_n`.
REQ-002 Port `clk`, input, width 1: pipeline clock.
REQ-003 Port `rst_n`, input, width 1: asynchronous active-low reset.
REQ-004 Port `IF_ID_Rs`, input, width 5: source register 1 of the instruction in ID.
REQ-005 Port `IF_ID_Rt`, input, width 5: source register 2 of the instruction in ID.
REQ-006 Port `ID_EX_Rt`, input, width 5: destination register of the instruction in EX.
REQ-007 Port `ID_EX_MemRead`, input, width 1: the instruction in EX is a load.
REQ-008 Port `branch_taken`, input, width 1: the branch or jump in ID resolved as taken.
REQ-009 Port `fp_issue`, input, width 1: the instruction in ID is a multi-cycle FP op.
REQ-010 Port `fp_latency`, input, width 4: number of stall cycles the FP op requires (0 to 15).
REQ-011 Port `PCWrite`, output, width 1: 1 = PC updates; 0 = PC holds.
REQ-012 Port `IF_ID_Write`, output, width 1: 1 = IF/ID captures a new instruction; 0 = IF/ID holds.
REQ-013 Port `IF_Flush`, output, width 1: 1 = IF/ID loads all-zero (NOP) on the next edge.
REQ-014 Port `ID_EX_Bubble`, output, width 1: 1 = ID/EX control fields are forced to zero.
REQ-015 Port `stall_count`, output, width 16: count of stall cycles, saturating.
REQ-016 Port `fsm_state`, output, width 2: current state (RUN=0, FP_WAIT=1, RELEASE=2).

Function
REQ-017 A load-use hazard SHALL be defined as: `ID_EX_MemRead`=1, `ID_EX_Rt`≠0, and `ID_EX_Rt` equals `IF_ID_Rs` or `IF_ID_Rt`.
REQ-018 Register 0 SHALL never produce a hazard.
REQ-019 "Stall outputs" SHALL be: `PCWrite`=0, `IF_ID_Write`=0, `IF_Flush`=0, `ID_EX_Bubble`=1.
REQ-020 "Normal outputs" SHALL be: `PCWrite`=1, `IF_ID_Write`=1, `IF_Flush`=0, `ID_EX_Bubble`=0.
REQ-021 All outputs except `stall_count` and `fsm_state` SHALL be combinational from the current state and inputs, so they act in the same cycle.
REQ-022 State RUN, priority order:
- (a) load-use hazard: drive stall outputs and remain in RUN; the hazard clears naturally once the bubble reaches EX.
- (b) else `fp_issue`=1 with `fp_latency`=N≥1: drive stall outputs; if N=1 go to RELEASE, otherwise load the counter with N−1 and go to FP_WAIT.
- (c) else `branch_taken`=1: drive normal outputs with `IF_Flush`=1.
- (d) else: drive normal outputs.
REQ-023 `fp_issue` with `fp_latency`=0 SHALL cause no stall and SHALL stay in RUN.
REQ-024 State FP_WAIT SHALL drive stall outputs every cycle.
- If the counter equals 1, go to RELEASE.
- Otherwise, decrement the counter.
- `branch_taken` and load-use SHALL be ignored in FP_WAIT.
REQ-025 Total stall for an FP op with latency N SHALL be exactly N cycles.
REQ-026 State RELEASE SHALL behave as RUN except that `fp_issue` is ignored; the next state is RUN, unless a load-use hazard occurs, in which case it stays RELEASE.
REQ-027 When load-use and `branch_taken` occur in the same cycle, load-use SHALL win and the flush SHALL NOT occur that cycle.
REQ-028 When load-use and `fp_issue` occur in the same cycle, load-use SHALL be served first; `fp_issue` is re-evaluated in the next cycle.
REQ-029 `stall_count` SHALL increment on every edge where `ID_EX_Bubble`=1 and SHALL saturate at 0xFFFF.

Reset
REQ-030 `rst_n`=0 SHALL asynchronously force: state RUN, counter 0, `stall_count` 0.
REQ-031 While `rst_n`=0, the combinational outputs SHALL be normal outputs with `IF_Flush`=1.
REQ-032 Reset asserted during FP_WAIT SHALL abort the stall immediately; after release, operation resumes in RUN.

Verification
REQ-033 Load-use: `ID_EX_MemRead`=1, `ID_EX_Rt`=5, `IF_ID_Rs`=5 for one cycle -> exactly one cycle of `PCWrite`=0, `ID_EX_Bubble`=1; `stall_count` becomes 1.
REQ-034 Zero register: `ID_EX_MemRead`=1, `ID_EX_Rt`=0, `IF_ID_Rt`=0 -> no stall.
REQ-035 FP latency: `fp_issue`=1 held, `fp_latency`=4 ->
- 4 stall cycles, states RUN, FP_WAIT, FP_WAIT, FP_WAIT;
- then RELEASE with normal outputs while `fp_issue` is still 1;
- then RUN.
REQ-036 Simultaneous events: load-use plus `branch_taken` in the same cycle -> a stall with `IF_Flush`=0; next cycle, with `branch_taken` still 1 -> `IF_Flush`=1.
REQ-037 Reset mid-operation: `fp_latency`=15, pull `rst_n` low in the 3rd FP_WAIT cycle -> state RUN and `stall_count`=0 immediately.
REQ-038 Saturation: preload 0xFFFE stall cycles, then stall 3 more -> `stall_count` reads 0xFFFF.
